// File: rtl/conv2d_shift_driver.sv
// Host-side driver for the shift-kernel convolution engine: frame loader, kernel-code server,
// result streamer. Optional feature macro: CONV_DRIVER_RELU_EN (clamp negative results to 0).
module conv2d_shift_driver #(
  parameter int pixel            = 4,
  parameter int kernel           = 3,
  parameter int stride           = 1,
  parameter int integer_width    = 10,
  parameter int fraction_width   = 10,
  parameter int kernel_bit_width = 6,
  parameter int read_latency     = 2
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic                                      start,
  output logic                                      busy,
  input  logic                                      kernel_wr_en,
  input  logic [3:0]                                kernel_wr_addr,
  input  logic [kernel_bit_width-1:0]               kernel_wr_data,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [integer_width+fraction_width-1:0]   in_data,
  output logic                                      conv_enableReadPixel,
  output logic [integer_width+fraction_width-1:0]   conv_Pixel_data,
  input  logic [3:0]                                conv_Kernel_address,
  output logic [kernel_bit_width-1:0]               conv_Kernel_data,
  input  logic                                      conv_done,
  output logic [12:0]                               conv_Output_Address,
  output logic                                      conv_Output_Enable,
  input  logic [integer_width+fraction_width-1:0]   conv_Output_data,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [integer_width+fraction_width-1:0]   out_data,
  output logic                                      out_last
);

  localparam int W    = integer_width + fraction_width;
  localparam int NPIX = pixel * pixel;
  localparam int OSZ  = (pixel - kernel) / stride + 1;
  localparam int NOUT = OSZ * OSZ;
  localparam int KK   = kernel * kernel;
  localparam int CW   = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_DONE,
    RD_ISSUE,
    RD_WAIT,
    OUT_HOLD
  } state_t;

  state_t                      state_q, state_d;
  logic [CW-1:0]               pix_cnt_q, pix_cnt_d;
  logic [12:0]                 out_cnt_q, out_cnt_d;
  logic [7:0]                  wait_q, wait_d;
  logic                        done_q;
  logic                        done_evt;
  logic                        pix_we_q, pix_we_d;
  logic [W-1:0]                pix_data_q, pix_data_d;
  logic                        oen_q, oen_d;
  logic [W-1:0]                out_data_q, out_data_d;
  logic                        out_last_q, out_last_d;
  logic [W-1:0]                rd_val;
  logic [kernel_bit_width-1:0] kdata_q, kdata_d;
  logic [kernel_bit_width-1:0] krf [KK];

  // Kernel register file: one register per entry; writes land only while idle.
  for (genvar gi = 0; gi < KK; gi++) begin : g_krf
    logic [kernel_bit_width-1:0] code_q;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        code_q <= '0;
      end else if (state_q == IDLE && kernel_wr_en && kernel_wr_addr == 4'(gi)) begin
        code_q <= kernel_wr_data;
      end
    end
    assign krf[gi] = code_q;
  end

  // Out-of-range fetch addresses match no entry and read back as zero.
  always_comb begin
    kdata_d = '0;
    for (int i = 0; i < KK; i++) begin
      if (conv_Kernel_address == 4'(i)) kdata_d = krf[i];
    end
  end

  // Rising edge only: done remains high from the previous frame until the first pixel write.
  assign done_evt = conv_done & ~done_q;

  always_comb begin
    rd_val = conv_Output_data;
`ifdef CONV_DRIVER_RELU_EN
    if (conv_Output_data[W-1]) rd_val = '0;
`endif
  end

  always_comb begin
    state_d    = state_q;
    pix_cnt_d  = pix_cnt_q;
    out_cnt_d  = out_cnt_q;
    wait_d     = wait_q;
    pix_we_d   = 1'b0;
    pix_data_d = pix_data_q;
    oen_d      = oen_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = LOAD;
          pix_cnt_d = '0;
        end
      end
      LOAD: begin
        if (in_valid) begin
          pix_we_d   = 1'b1;
          pix_data_d = in_data;
          pix_cnt_d  = pix_cnt_q + 16'd1;
          if (pix_cnt_q == 16'(NPIX - 1)) state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (done_evt) begin
          state_d   = RD_ISSUE;
          out_cnt_d = '0;
          oen_d     = 1'b1;
        end
      end
      RD_ISSUE: begin
        state_d = RD_WAIT;
        wait_d  = '0;
      end
      RD_WAIT: begin
        // Address has been stable since RD_ISSUE, so data is settled by this edge.
        if (wait_q == 8'(read_latency - 1)) begin
          out_data_d = rd_val;
          out_last_d = (out_cnt_q == 13'(NOUT - 1));
          state_d    = OUT_HOLD;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      OUT_HOLD: begin
        if (out_ready) begin
          if (out_last_q) begin
            state_d    = IDLE;
            oen_d      = 1'b0;
            out_last_d = 1'b0;
          end else begin
            out_cnt_d = out_cnt_q + 13'd1;
            state_d   = RD_ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pix_cnt_q  <= '0;
      out_cnt_q  <= '0;
      wait_q     <= '0;
      done_q     <= 1'b0;
      pix_we_q   <= 1'b0;
      pix_data_q <= '0;
      oen_q      <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      kdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      pix_cnt_q  <= pix_cnt_d;
      out_cnt_q  <= out_cnt_d;
      wait_q     <= wait_d;
      done_q     <= conv_done;
      pix_we_q   <= pix_we_d;
      pix_data_q <= pix_data_d;
      oen_q      <= oen_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      kdata_q    <= kdata_d;
    end
  end

  assign busy                 = (state_q != IDLE);
  assign in_ready             = (state_q == LOAD);
  assign out_valid            = (state_q == OUT_HOLD);
  assign out_data             = out_data_q;
  assign out_last             = out_last_q;
  assign conv_enableReadPixel = pix_we_q;
  assign conv_Pixel_data      = pix_data_q;
  assign conv_Kernel_data     = kdata_q;
  assign conv_Output_Address  = out_cnt_q;
  assign conv_Output_Enable   = oen_q;

endmodule

// File: doc/conv2d_shift_driver.md
Name: conv2d_shift_driver

Overview:
- Host-side companion to the shift-kernel valid-convolution engine.
- Streams one frame of pixels into the engine's pixel-write port and serves the engine's kernel-code fetches from a local register file.
- Waits for the engine's done flag, then reads the output BRAM through the engine's read port and re-streams the results on a valid/ready output.

Parameters:
- pixel, 4, input frame side length (frame is pixel x pixel)
- kernel, 3, kernel side length
- stride, 1, convolution stride; must match the engine
- integer_width, 10, integer bits of a data word
- fraction_width, 10, fraction bits of a data word
- kernel_bit_width, 6, kernel code width: [MSB] negate, [MSB-1] right-shift direction, [MSB-2:0] shift amount
- read_latency, 2, cycles from conv_Output_Address valid to conv_Output_data valid

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a frame, honoured only in IDLE
- busy  out  1  high in every state except IDLE
- kernel_wr_en  in  1  kernel register-file write strobe
- kernel_wr_addr  in  4  kernel entry index, 0..kernel*kernel-1
- kernel_wr_data  in  kernel_bit_width  kernel shift code
- in_valid  in  1  upstream pixel valid
- in_ready  out  1  pixel accepted when in_valid && in_ready
- in_data  in  W=integer_width+fraction_width  signed pixel
- conv_enableReadPixel  out  1  engine pixel write strobe
- conv_Pixel_data  out  W  engine pixel write data
- conv_Kernel_address  in  4  engine kernel fetch index
- conv_Kernel_data  out  kernel_bit_width  kernel code for conv_Kernel_address
- conv_done  in  1  engine done flag
- conv_Output_Address  out  13  engine output BRAM read address
- conv_Output_Enable  out  1  high while reading
- conv_Output_data  in  W  engine output BRAM read data
- out_valid  out  1  result valid
- out_ready  in  1  downstream ready
- out_data  out  W  signed result
- out_last  out  1  high with the final result of a frame

Behaviour:
- Derived values: NPIX = pixel*pixel; OSZ = (pixel-kernel)/stride+1; NOUT = OSZ*OSZ.
- Reset (reset_n low, async): state IDLE; all outputs 0; pixel and output counters 0; kernel register file cleared to 0; done_q 0.
- Reset mid-frame aborts the frame with no partial output. The engine must be reset in the same cycle.
- Kernel register file:
  - kernel_wr_en writes entry kernel_wr_addr in IDLE only. Writes while busy are ignored.
  - Writes with address >= kernel*kernel are ignored.
  - conv_Kernel_data is registered, 1 cycle after conv_Kernel_address. An out-of-range address returns 0.
- done_q is a registered copy of conv_done. The done event is conv_done && !done_q, a rising edge. A level test is not used, because done stays high from the previous frame until the first pixel write.
- FSM:
  - IDLE: in_ready=0. On start, go to LOAD with pixel count cleared.
  - LOAD: in_ready=1.
    - Each accepted beat: next cycle conv_enableReadPixel=1 and conv_Pixel_data=the beat. Otherwise conv_enableReadPixel=0.
    - Gaps in in_valid are allowed; the engine holds its address.
    - After the NPIX-th accepted beat: in_ready drops the same edge, go to WAIT_DONE.
  - WAIT_DONE: in_ready=0. On the done event, go to RD_ISSUE with output count cleared.
    - A done event seen during LOAD is ignored.
  - RD_ISSUE: drive conv_Output_Address=output count and conv_Output_Enable=1. Go to RD_WAIT.
  - RD_WAIT: wait read_latency cycles while holding the address.
    - Capture conv_Output_data into out_data.
    - out_last = (count == NOUT-1).
    - Go to OUT_HOLD.
  - OUT_HOLD: out_valid=1; out_data and out_last stay stable until out_ready.
    - On handshake: out_valid drops the next cycle.
    - If this was the last result: go to IDLE and clear conv_Output_Enable.
    - Otherwise: increment the count and go to RD_ISSUE.
- start while busy is ignored. out_ready asserted without out_valid has no effect.
- Output order is raster: address i*OSZ+j. Throughput is one result per read_latency+2 cycles minimum.

Optional Feature:
- Macro CONV_DRIVER_RELU_EN.
- Defined: the value captured in RD_WAIT is replaced by 0 when its sign bit is set. out_last timing is unchanged.
- Undefined: the raw engine data passes unchanged.

Test Plan:
- Kernel all codes 6'b000000 (x1); 16 pixels of 1.0 (20'h00400) -> 4 results of 9.0 (20'h02400), out_last only on the 4th; busy low afterwards.
- Kernel all 6'b100000 (x-1); same pixels -> four results 20'hFDC00. With CONV_DRIVER_RELU_EN -> four results 20'h00000.
- Pixels with in_valid toggled every other cycle -> exactly 16 conv_enableReadPixel pulses; results identical to the first scenario.
- Hold out_ready low for 10 cycles on result 2 -> out_data stable, out_valid high throughout, no result lost or duplicated.
- kernel_wr_en while busy, and start pulsed during LOAD -> both ignored; the frame completes with the original kernel.
- reset_n low for 1 cycle mid-LOAD (after 7 pixels) -> all outputs 0, IDLE. A fresh start then produces correct results.
